// File: rtl/mat_store.sv
// Two-slot matrix store: row-major stream loader with a rising-edge-triggered,
// one-cycle-latency element read port and per-slot dimension/valid metadata.
module mat_store #(
  parameter int DIM_WIDTH  = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_start,
  input  logic                  wr_slot,
  input  logic [DIM_WIDTH-1:0]  wr_m,
  input  logic [DIM_WIDTH-1:0]  wr_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_elem,
  output logic                  wr_busy,
  output logic                  wr_done,
  output logic                  wr_error,
  output logic [1:0]            slot_valid,
  output logic [DIM_WIDTH-1:0]  slot0_m,
  output logic [DIM_WIDTH-1:0]  slot0_n,
  output logic [DIM_WIDTH-1:0]  slot1_m,
  output logic [DIM_WIDTH-1:0]  slot1_n,
  input  logic                  rd_en,
  input  logic                  rd_slot_idx,
  input  logic [DIM_WIDTH-1:0]  rd_row_idx,
  input  logic [DIM_WIDTH-1:0]  rd_col_idx,
  output logic [DATA_WIDTH-1:0] rd_elem,
  output logic                  rd_elem_valid,
  output logic [1:0]            wr_state_dbg
);
  // Handshake: a load is one wr_start pulse followed by m*n wr_valid strobes;
  // a read fires on the rising edge of rd_en and answers with a one-cycle
  // rd_elem_valid pulse on the next cycle, rd_elem holding until the next pulse.

  localparam int AW = 2 * DIM_WIDTH + 1;
  localparam logic [DIM_WIDTH-1:0] ONE = DIM_WIDTH'(1);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_LOAD = 2'd1,
    W_DONE = 2'd2
  } wstate_e;

  wstate_e               state_q, state_d;
  logic                  slot_q, slot_d;
  logic [DIM_WIDTH-1:0]  m_q, m_d, n_q, n_d;
  logic [DIM_WIDTH-1:0]  row_q, row_d, col_q, col_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]            sv_q, sv_d;
  logic [DIM_WIDTH-1:0]  s0m_q, s0m_d, s0n_q, s0n_d, s1m_q, s1m_d, s1n_q, s1n_d;
  logic                  mem_we;
  logic                  last_elem;

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<AW)-1];

  logic                  rd_en_q, rd_rise, rd_hit;
  logic [DIM_WIDTH-1:0]  rd_m, rd_n;
  logic [DATA_WIDTH-1:0] rd_elem_q;
  logic                  rd_valid_q;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    m_d       = m_q;
    n_d       = n_q;
    row_d     = row_q;
    col_d     = col_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    sv_d      = sv_q;
    s0m_d     = s0m_q;
    s0n_d     = s0n_q;
    s1m_d     = s1m_q;
    s1n_d     = s1n_q;
    mem_we    = 1'b0;
    last_elem = (row_q == m_q - ONE) && (col_q == n_q - ONE);
    case (state_q)
      W_IDLE: begin
        if (wr_start) begin
          if (wr_m == '0 || wr_n == '0) begin
            err_d = 1'b1;
          end else begin
            slot_d        = wr_slot;
            m_d           = wr_m;
            n_d           = wr_n;
            row_d         = '0;
            col_d         = '0;
            busy_d        = 1'b1;
            sv_d[wr_slot] = 1'b0;
            state_d       = W_LOAD;
          end
        end
      end
      W_LOAD: begin
        if (wr_valid) begin
          mem_we = 1'b1;
          if (col_q == n_q - ONE) begin
            col_d = '0;
            row_d = row_q + ONE;
          end else begin
            col_d = col_q + ONE;
          end
          // Completion is published on entry to W_DONE so wr_done lands
          // exactly one cycle after the final strobe.
          if (last_elem) begin
            state_d      = W_DONE;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            sv_d[slot_q] = 1'b1;
            if (slot_q) begin
              s1m_d = m_q;
              s1n_d = n_q;
            end else begin
              s0m_d = m_q;
              s0n_d = n_q;
            end
          end
        end
      end
      W_DONE:  state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= W_IDLE;
      slot_q  <= 1'b0;
      m_q     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sv_q    <= 2'b00;
      s0m_q   <= '0;
      s0n_q   <= '0;
      s1m_q   <= '0;
      s1n_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      m_q     <= m_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sv_q    <= sv_d;
      s0m_q   <= s0m_d;
      s0n_q   <= s0n_d;
      s1m_q   <= s1m_d;
      s1n_q   <= s1n_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[{slot_q, row_q, col_q}] <= wr_elem;
  end

  // Out-of-range or invalid-slot reads still pulse, returning zero data.
  assign rd_m    = rd_slot_idx ? s1m_q : s0m_q;
  assign rd_n    = rd_slot_idx ? s1n_q : s0n_q;
  assign rd_hit  = sv_q[rd_slot_idx] && (rd_row_idx < rd_m) && (rd_col_idx < rd_n);
  assign rd_rise = rd_en && !rd_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_elem_q  <= '0;
    end else begin
      rd_en_q    <= rd_en;
      rd_valid_q <= rd_rise;
      if (rd_rise) rd_elem_q <= rd_hit ? mem_q[{rd_slot_idx, rd_row_idx, rd_col_idx}] : '0;
    end
  end

  assign wr_busy       = busy_q;
  assign wr_done       = done_q;
  assign wr_error      = err_q;
  assign slot_valid    = sv_q;
  assign slot0_m       = s0m_q;
  assign slot0_n       = s0n_q;
  assign slot1_m       = s1m_q;
  assign slot1_n       = s1n_q;
  assign rd_elem       = rd_elem_q;
  assign rd_elem_valid = rd_valid_q;
  assign wr_state_dbg  = state_q;

endmodule

// File: tb/tb_mat_store.sv
// Bench for mat_store: directed loads/reads against an element-count model of
// the store, plus literal expectations taken from hand-worked scenarios.
module tb_mat_store;
  localparam int DW = 3;
  localparam int EW = 8;

  logic          clk;
  logic          rst_n;
  logic          wr_start, wr_slot, wr_valid;
  logic [DW-1:0] wr_m, wr_n;
  logic [EW-1:0] wr_elem;
  logic          wr_busy, wr_done, wr_error;
  logic [1:0]    slot_valid;
  logic [DW-1:0] slot0_m, slot0_n, slot1_m, slot1_n;
  logic          rd_en, rd_slot_idx;
  logic [DW-1:0] rd_row_idx, rd_col_idx;
  logic [EW-1:0] rd_elem;
  logic          rd_elem_valid;
  logic [1:0]    wr_state_dbg;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 0;

  mat_store #(.DIM_WIDTH(DW), .DATA_WIDTH(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_start(wr_start), .wr_slot(wr_slot), .wr_m(wr_m), .wr_n(wr_n),
    .wr_valid(wr_valid), .wr_elem(wr_elem),
    .wr_busy(wr_busy), .wr_done(wr_done), .wr_error(wr_error),
    .slot_valid(slot_valid),
    .slot0_m(slot0_m), .slot0_n(slot0_n), .slot1_m(slot1_m), .slot1_n(slot1_n),
    .rd_en(rd_en), .rd_slot_idx(rd_slot_idx), .rd_row_idx(rd_row_idx),
    .rd_col_idx(rd_col_idx), .rd_elem(rd_elem), .rd_elem_valid(rd_elem_valid),
    .wr_state_dbg(wr_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: matrix contents, per-slot metadata and an in-flight element count
  logic [EW-1:0] m_mem [2][8][8];
  bit            m_sv [2];
  int            m_dm [2];
  int            m_dn [2];
  bit            m_busy, m_done, m_err, m_rv, m_en_q;
  logic [EW-1:0] m_rd;
  int            m_slot, m_lm, m_ln, m_k;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sv[0] = 0; m_sv[1] = 0;
      m_dm[0] = 0; m_dm[1] = 0; m_dn[0] = 0; m_dn[1] = 0;
      m_busy = 0; m_done = 0; m_err = 0; m_rv = 0; m_en_q = 0; m_rd = '0;
      m_k = 0;
    end else begin
      if (rd_en && !m_en_q) begin
        m_rv = 1;
        if (m_sv[rd_slot_idx] && int'(rd_row_idx) < m_dm[rd_slot_idx]
            && int'(rd_col_idx) < m_dn[rd_slot_idx])
          m_rd = m_mem[rd_slot_idx][rd_row_idx][rd_col_idx];
        else
          m_rd = '0;
      end else begin
        m_rv = 0;
      end
      m_en_q = rd_en;
      m_done = 0;
      m_err  = 0;
      if (!m_busy) begin
        if (wr_start) begin
          if (wr_m == 0 || wr_n == 0) begin
            m_err = 1;
          end else begin
            m_busy = 1; m_slot = int'(wr_slot); m_lm = int'(wr_m); m_ln = int'(wr_n);
            m_k = 0; m_sv[m_slot] = 0;
          end
        end
      end else if (wr_valid) begin
        m_mem[m_slot][m_k / m_ln][m_k % m_ln] = wr_elem;
        m_k++;
        if (m_k == m_lm * m_ln) begin
          m_busy = 0; m_done = 1; m_sv[m_slot] = 1;
          m_dm[m_slot] = m_lm; m_dn[m_slot] = m_ln;
        end
      end
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wr_busy", 32'(wr_busy), 32'(m_busy));
      chk("wr_done", 32'(wr_done), 32'(m_done));
      chk("wr_error", 32'(wr_error), 32'(m_err));
      chk("slot_valid", 32'(slot_valid), 32'({m_sv[1], m_sv[0]}));
      chk("slot0_m", 32'(slot0_m), 32'(m_dm[0]));
      chk("slot0_n", 32'(slot0_n), 32'(m_dn[0]));
      chk("slot1_m", 32'(slot1_m), 32'(m_dm[1]));
      chk("slot1_n", 32'(slot1_n), 32'(m_dn[1]));
      chk("rd_elem_valid", 32'(rd_elem_valid), 32'(m_rv));
      chk("rd_elem", 32'(rd_elem), 32'(m_rd));
    end
  end

  // driver tasks
  logic [EW-1:0] ld_data [0:63];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit slot, input int m, input int n, input bit gap);
    wr_start = 1; wr_slot = slot; wr_m = DW'(m); wr_n = DW'(n);
    tick();
    wr_start = 0;
    for (int i = 0; i < m * n; i++) begin
      wr_valid = 1; wr_elem = ld_data[i];
      tick();
      wr_valid = 0;
      if (i == m * n - 1) begin
        chk("done_after_last", 32'(wr_done), 32'd1);
        chk("busy_after_last", 32'(wr_busy), 32'd0);
      end else if (gap) begin
        tick();
      end
    end
    tick();
    chk("done_one_cycle", 32'(wr_done), 32'd0);
  endtask

  task automatic rd(input bit slot, input int row, input int col, input int hold,
                    input logic [EW-1:0] exp);
    rd_en = 1; rd_slot_idx = slot; rd_row_idx = DW'(row); rd_col_idx = DW'(col);
    tick();
    chk("rd_pulse", 32'(rd_elem_valid), 32'd1);
    chk("rd_data", 32'(rd_elem), 32'(exp));
    for (int h = 1; h < hold; h++) begin
      tick();
      chk("rd_no_repeat", 32'(rd_elem_valid), 32'd0);
    end
    rd_en = 0;
    tick();
  endtask

  initial begin
    rst_n = 0; wr_start = 0; wr_slot = 0; wr_m = '0; wr_n = '0;
    wr_valid = 0; wr_elem = '0; rd_en = 0; rd_slot_idx = 0;
    rd_row_idx = '0; rd_col_idx = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(wr_busy), 32'd0);
    chk("rst_done", 32'(wr_done), 32'd0);
    chk("rst_error", 32'(wr_error), 32'd0);
    chk("rst_slot_valid", 32'(slot_valid), 32'd0);
    chk("rst_slot0_m", 32'(slot0_m), 32'd0);
    chk("rst_slot1_n", 32'(slot1_n), 32'd0);
    chk("rst_rd_valid", 32'(rd_elem_valid), 32'd0);
    chk("rst_rd_elem", 32'(rd_elem), 32'd0);
    rst_n = 1;
    tick();
    cmp_en = 1;

    // 2x3 into slot 0, continuous strobes
    for (int i = 0; i < 6; i++) ld_data[i] = EW'(i + 1);
    load(1'b0, 2, 3, 1'b0);
    chk("l0_slot_valid", 32'(slot_valid), 32'd1);
    chk("l0_m", 32'(slot0_m), 32'd2);
    chk("l0_n", 32'(slot0_n), 32'd3);

    rd(1'b0, 1, 2, 3, 8'd6);
    rd(1'b0, 1, 0, 1, 8'd4);
    rd(1'b0, 2, 0, 1, 8'd0);
    rd(1'b0, 0, 3, 1, 8'd0);
    rd(1'b1, 0, 0, 1, 8'd0);

    // zero-dimension start is rejected
    wr_start = 1; wr_slot = 1; wr_m = 3'd0; wr_n = 3'd4;
    tick();
    wr_start = 0;
    chk("err_pulse", 32'(wr_error), 32'd1);
    chk("err_busy", 32'(wr_busy), 32'd0);
    chk("err_slot_valid", 32'(slot_valid), 32'd1);
    tick();
    chk("err_one_cycle", 32'(wr_error), 32'd0);

    // gapped 3x3 into slot 1 while slot 0 is read
    for (int i = 0; i < 9; i++) ld_data[i] = EW'(10 + i);
    fork
      load(1'b1, 3, 3, 1'b1);
      begin
        tick(); tick();
        rd(1'b0, 0, 0, 1, 8'd1);
      end
    join
    chk("l1_slot_valid", 32'(slot_valid), 32'd3);
    chk("l1_m", 32'(slot1_m), 32'd3);
    rd(1'b1, 2, 2, 1, 8'd18);
    rd(1'b1, 1, 0, 2, 8'd13);

    // reload slot 0, read it mid-load, then reset after 4 elements
    wr_start = 1; wr_slot = 0; wr_m = 3'd3; wr_n = 3'd3;
    tick();
    wr_start = 0;
    chk("reload_invalid", 32'(slot_valid), 32'd2);
    chk("reload_busy", 32'(wr_busy), 32'd1);
    rd(1'b0, 0, 0, 1, 8'd0);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; wr_elem = EW'(40 + i);
      tick();
    end
    wr_valid = 0;
    rst_n = 0;
    tick();
    chk("midrst_slot_valid", 32'(slot_valid), 32'd0);
    chk("midrst_busy", 32'(wr_busy), 32'd0);
    rst_n = 1;
    tick();
    rd(1'b0, 0, 0, 1, 8'd0);
    chk("post_rst_slot0_m", 32'(slot0_m), 32'd0);
    tick();

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/mat_store.md
Name: mat_store

Overview:
- Two-slot matrix storage that sits directly upstream of the matrix arithmetic units. It feeds them operands through a level-`rd_en` / pulse-`rd_elem_valid` read port.
- Matrices are loaded as a row-major element stream from the input front-end.
- Per-slot dimension and valid metadata are exported so operator units can run their own validity checks.

Parameters:
- DIM_WIDTH, 3, width of row/column dimensions and indices (max dimension 7).
- DATA_WIDTH, 8, element width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_start  in  1  one-cycle pulse; begins loading a matrix
- wr_slot  in  1  target slot, sampled on wr_start
- wr_m  in  DIM_WIDTH  row count, sampled on wr_start
- wr_n  in  DIM_WIDTH  column count, sampled on wr_start
- wr_valid  in  1  element strobe, one element per high cycle
- wr_elem  in  DATA_WIDTH  element data, row-major order
- wr_busy  out  1  load in progress
- wr_done  out  1  one-cycle pulse after the last element is stored
- wr_error  out  1  one-cycle pulse on rejected wr_start
- slot_valid  out  2  bit i set when slot i holds a complete matrix
- slot0_m, slot0_n  out  DIM_WIDTH each  dimensions of slot 0
- slot1_m, slot1_n  out  DIM_WIDTH each  dimensions of slot 1
- rd_en  in  1  read request (level)
- rd_slot_idx  in  1  read slot
- rd_row_idx  in  DIM_WIDTH  read row
- rd_col_idx  in  DIM_WIDTH  read column
- rd_elem  out  DATA_WIDTH  read data
- rd_elem_valid  out  1  one-cycle pulse; rd_elem is valid this cycle

Behaviour:
- Storage: 2 × 2^(2·DIM_WIDTH) words, addressed {slot, row, col}. Contents are not reset.
- Reset values: wr_busy=0, wr_done=0, wr_error=0, slot_valid=2'b00, all slotX_m/n=0, rd_elem=0, rd_elem_valid=0. Internal counters and latched rd_en = 0.
- Write FSM states: W_IDLE, W_LOAD, W_DONE.
- W_IDLE, on wr_start:
  - If wr_m==0 or wr_n==0: pulse wr_error next cycle, stay in W_IDLE, slot metadata untouched.
  - Otherwise: latch slot/m/n, clear slot_valid[wr_slot], zero the row/col counters, set wr_busy, go to W_LOAD.
- W_LOAD: each wr_valid cycle writes wr_elem at {slot, row_cnt, col_cnt}.
  - col_cnt increments; it wraps to 0 at n-1, at which point row_cnt increments.
  - On the element at (m-1, n-1): go to W_DONE.
  - wr_valid low cycles stall the load with no effect.
- W_DONE (one cycle):
  - Set slot_valid[slot], slotX_m/n = latched dims.
  - Pulse wr_done, clear wr_busy, return to W_IDLE.
  - wr_done is high exactly one cycle after the final element's wr_valid cycle.
- wr_start while wr_busy: ignored, no error.
- wr_valid in W_IDLE: ignored.
- Read timing:
  - A read is triggered by a rising edge of rd_en (rd_en=1 while the registered previous rd_en=0).
  - Exactly one cycle later: rd_elem_valid=1 and rd_elem = stored word. Both are registered; latency is 1.
  - Holding rd_en high yields no further pulses.
  - Consumers must drop rd_en for at least one cycle between reads (PRE/WAIT protocol).
- Read data forcing: rd_elem reads 0 (rd_elem_valid still pulses, so a consumer never deadlocks) when:
  - slot_valid[rd_slot_idx]==0, or
  - rd_row_idx ≥ slot m, or
  - rd_col_idx ≥ slot n.
- rd_elem holds its value between pulses.
- Simultaneous read and write:
  - Different slots are independent, both in the same cycle.
  - Reading the slot under load returns 0, because its valid bit is cleared.
- Reset mid-load: the load is discarded, all slots become invalid, and the FSM returns to W_IDLE.
- Reloading a valid slot: the slot becomes invalid from the cycle after wr_start until its W_DONE.

Test Plan:
- Load slot 0 with 2×3 = {1,2,3,4,5,6}, continuous wr_valid -> wr_done pulses one cycle after the 6th element; slot_valid=01; slot0_m=2, slot0_n=3.
- Read slot 0 (1,2) with an rd_en low→high edge, held high 3 cycles -> a single rd_elem_valid pulse one cycle after the edge, rd_elem=6.
- Read slot 0 (2,0) (row out of range) and slot 1 (0,0) (invalid slot) -> each returns one rd_elem_valid pulse with rd_elem=0.
- wr_start with wr_m=0, wr_n=4 -> wr_error pulse; wr_busy stays 0; slot_valid unchanged.
- Load slot 1 as 3×3 with wr_valid gapped every other cycle, while reading slot 0 (0,0) -> slot 0 read returns 1; slot 1 completes after 9 strobes; slot_valid=11.
- Assert rst_n=0 after 4 elements of a slot-0 reload -> after reset slot_valid=00, wr_busy=0, and a read of slot 0 returns 0.
